div_exp: RTL and testbench

Exponent-path counterpart of the multiplier exponent stage in the quantized MAC datapath. It accepts an exponent in the packed multiplier-output format and restores the plain 4-bit exponent sum. It then subtracts a divisor exponent and delivers the 4-bit quotient exponent with a borrow (underflow) flag. The block is a 2-stage elastic pipeline with valid/ready handshakes on both sides and a saturating underflow event counter.

---
 rtl/div_exp.sv | 91 +++++++++
 tb/tb_div_exp.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_exp.sv
// Exponent divide path: unpacks the multiplier's packed exponent, subtracts a divisor
// exponent and delivers quotient exponent plus borrow through a 2-stage elastic pipeline.
module div_exp (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] pexp,
    input  logic [3:0] exp_d,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] result,
    output logic       borrow,
    input  logic       uf_clr,
    output logic [7:0] uf_cnt
);

    logic [1:0] w_s_hi;
    logic [3:0] w_s;
    logic       w_s1_adv;
    logic       w_s2_adv;
    logic       w_accept;
    logic       w_uf_evt;
    logic [4:0] w_diff;

    logic       r_s1_valid;
    logic [3:0] r_s1_s;
    logic [3:0] r_s1_d;
    logic       r_s2_valid;
    logic [3:0] r_s2_result;
    logic       r_s2_borrow;
    logic [7:0] r_uf_cnt;

    // Packed format stores S[3:2] biased by +1; undo the bias and swap the halves back.
    always_comb begin
        w_s_hi = pexp[1:0] - 2'd1;
        w_s    = {w_s_hi, pexp[3:2]};
    end

    always_comb begin
        w_s2_adv = ~r_s2_valid | out_ready;
        w_s1_adv = ~r_s1_valid | w_s2_adv;
        w_accept = in_valid & w_s1_adv;
        w_diff   = {1'b0, r_s1_s} - {1'b0, r_s1_d};
        w_uf_evt = r_s2_valid & out_ready & r_s2_borrow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_s     <= 4'd0;
            r_s1_d     <= 4'd0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_s <= w_s;
                r_s1_d <= exp_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= 4'd0;
            r_s2_borrow <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_result <= w_diff[3:0];
            r_s2_borrow <= w_diff[4];
        end
    end

    // Clear wins over a same-cycle underflow event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uf_cnt <= 8'd0;
        end else if (uf_clr) begin
            r_uf_cnt <= 8'd0;
        end else if (w_uf_evt && (r_uf_cnt != 8'hFF)) begin
            r_uf_cnt <= r_uf_cnt + 8'd1;
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign result    = r_s2_result;
    assign borrow    = r_s2_borrow;
    assign uf_cnt    = r_uf_cnt;

endmodule

// File: tb/tb_div_exp.sv
// Bench for div_exp: scoreboard of expected {borrow,result} per accepted beat plus
// an underflow counter model, with directed scenario tasks.
module tb_div_exp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] pexp;
    logic [3:0] exp_d;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       borrow;
    logic       uf_clr;
    logic [7:0] uf_cnt;

    int checks = 0;
    int errors = 0;

    logic [4:0] q[$];
    logic [3:0] s_tbl[16];
    logic [7:0] m_uf = 8'd0;

    div_exp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pexp     (pexp),
        .exp_d    (exp_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .borrow   (borrow),
        .uf_clr   (uf_clr),
        .uf_cnt   (uf_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic [3:0] p, input logic [3:0] d);
        logic [3:0] s;
        s = s_tbl[p];
        return {1'b0, s} - {1'b0, d};
    endfunction

    // Monitor: inputs change just after posedge, so values seen at negedge hold through the edge.
    always @(negedge clk) begin
        logic       hs;
        logic [4:0] e;
        e = 5'd0;
        if (!rst_n) begin
            m_uf = 8'd0;
        end else begin
            checks++;
            if (uf_cnt !== m_uf) begin
                errors++;
                $display("FAIL uf_cnt_model: got %0d expected %0d at %0t", uf_cnt, m_uf, $time);
            end
            hs = out_valid && out_ready;
            if (hs) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: result=%0d borrow=%0d with empty scoreboard",
                             result, borrow);
                end else begin
                    e = q.pop_front();
                    if ({borrow, result} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got borrow=%0d result=%0d expected borrow=%0d result=%0d at %0t",
                                 borrow, result, e[4], e[3:0], $time);
                    end
                end
            end
            if (uf_clr) m_uf = 8'd0;
            else if (hs && e[4] && m_uf != 8'hFF) m_uf = m_uf + 8'd1;
            if (in_valid && in_ready) q.push_back(model(pexp, exp_d));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still pending, out_valid=%0d", q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; pexp = 4'd0; exp_d = 4'd0; out_ready = 1'b0; uf_clr = 1'b0;
        step();
        step();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (result !== 4'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
        if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", borrow); end
        if (uf_cnt !== 8'd0) begin errors++; $display("FAIL reset_uf_cnt: got %0d expected 0", uf_cnt); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        pexp = 4'b0011; exp_d = 4'd5; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid got %b expected 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 4'd3 || borrow !== 1'b0)
        begin
            errors++;
            $display("FAIL basic_out: got v=%b r=%0d b=%b expected v=1 r=3 b=0", out_valid, result, borrow);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_dup: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_underflow();
        pexp = 4'b1001; exp_d = 4'd5; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks += 2;
        if (out_valid !== 1'b1 || result !== 4'd13 || borrow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_out: got v=%b r=%0d b=%b expected v=1 r=13 b=1", out_valid, result, borrow);
        end
        if (uf_cnt !== 8'd0) begin errors++; $display("FAIL underflow_pre_cnt: got %0d expected 0", uf_cnt); end
        step();
        checks++;
        if (uf_cnt !== 8'd1) begin errors++; $display("FAIL underflow_cnt: got %0d expected 1", uf_cnt); end
    endtask

    task automatic test_unpack_sweep();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pexp = 4'(i); exp_d = 4'd0; in_valid = 1'b1;
            step();
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b1 || result !== 4'd12 || borrow !== 1'b0) begin
                    errors++;
                    $display("FAIL unpack_wrap: got v=%b r=%0d b=%b expected v=1 r=12 b=0",
                             out_valid, result, borrow);
                end
            end
        end
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [3:0] bp[4];
        logic [3:0] bd[4];
        logic [4:0] e0;
        logic       fire;
        int         sent;
        bp[0] = 4'b0111; bp[1] = 4'b1010; bp[2] = 4'b0001; bp[3] = 4'b1100;
        bd[0] = 4'd3;    bd[1] = 4'd9;    bd[2] = 4'd0;    bd[3] = 4'd15;
        e0 = model(bp[0], bd[0]);
        sent = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (sent < 4);
            pexp = (sent < 4) ? bp[sent] : 4'd0;
            exp_d = (sent < 4) ? bd[sent] : 4'd0;
            @(negedge clk);
            fire = in_valid && in_ready;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || result !== e0[3:0] || borrow !== e0[4]) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b r=%0d b=%b expected v=1 r=%0d b=%0d",
                             out_valid, result, borrow, e0[3:0], e0[4]);
                end
            end
            step();
            if (fire) sent++;
        end
        checks++;
        if (sent != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_in_ready: accepted %0d in_ready=%b expected 2 and 0", sent, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = (sent < 4);
            pexp = (sent < 4) ? bp[sent] : 4'd0;
            exp_d = (sent < 4) ? bd[sent] : 4'd0;
            @(negedge clk);
            fire = in_valid && in_ready;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL release_gap: out_valid got %b expected 1 in release cycle %0d", out_valid, k);
            end
            step();
            if (fire) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 4) begin errors++; $display("FAIL release_accept: accepted %0d expected 4", sent); end
        wait_drain();
    endtask

    task automatic test_counter();
        out_ready = 1'b1;
        pexp = 4'b0001; exp_d = 4'd1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        wait_drain();
        checks++;
        if (uf_cnt !== 8'd255) begin errors++; $display("FAIL uf_saturate: got %0d expected 255", uf_cnt); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || borrow !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup: got v=%b b=%b expected v=1 b=1", out_valid, borrow);
        end
        uf_clr = 1'b1;
        step();
        uf_clr = 1'b0;
        checks++;
        if (uf_cnt !== 8'd0) begin errors++; $display("FAIL uf_clr_priority: got %0d expected 0", uf_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        pexp = 4'b0110; exp_d = 4'd2; in_valid = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got in_ready=%b out_valid=%b expected 0 and 1", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 4'd0 || borrow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got v=%b r=%0d b=%b in_ready=%b expected 0 0 0 1",
                     out_valid, result, borrow, in_ready);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        pexp = 4'b1111; exp_d = 4'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_early: out_valid got %b expected 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 4'd7 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_beat: got v=%b r=%0d b=%b expected v=1 r=7 b=0", out_valid, result, borrow);
        end
        wait_drain();
    endtask

    initial begin
        for (int s = 0; s < 16; s++) begin
            logic [3:0] sv;
            logic [3:0] code;
            sv = 4'(s);
            code = {sv[1:0], sv[3:2] + 2'd1};
            s_tbl[code] = sv;
        end
        test_reset();
        test_basic();
        test_underflow();
        test_unpack_sweep();
        test_backpressure();
        test_counter();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
